// File: rtl/paint_pkg.sv
// Shared constants and types for the paint cursor controller.
// Grid geometry is fixed by the 160x120 framebuffer.
package paint_pkg;

    localparam int GRID_W   = 160;
    localparam int GRID_H   = 120;
    localparam int FB_DEPTH = GRID_W * GRID_H;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 12;
    localparam int X_W      = $clog2(GRID_W);
    localparam int Y_W      = $clog2(GRID_H);

    typedef enum logic {
        IDLE,
        CLEAR
    } ctrl_state_t;

    function automatic logic [ADDR_W-1:0] cell_index(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a
// stability counter that gates changes of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/paint_cursor_ctrl.sv
// Cursor movement, paint writes and full-screen clear sweep
// driving the framebuffer write port of the VGA display block.
module paint_cursor_ctrl
    import paint_pkg::*;
#(
    parameter int                  DEBOUNCE_CYC = 1000000,
    parameter int                  MOVE_CYC     = 5000000,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 12'hFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_paint,
    input  logic                btn_clear,
    input  logic [COLOUR_W-1:0] sw_colour,
    output logic [ADDR_W-1:0]   cursor_pos,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [COLOUR_W-1:0] wr_data,
    output logic                clearing
);

    localparam int              RPT_W     = $clog2(MOVE_CYC + 1);
    localparam logic [X_W-1:0]  X_MAX     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]  Y_MAX     = Y_W'(GRID_H - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    logic [5:0] raw;
    logic [5:0] lvl;
    logic [5:0] lvl_q;
    logic       right, left, down, up, paint, clr_lvl;
    logic       dir_rise, clr_rise;

    assign raw = {btn_clear, btn_paint, btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < 6; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .level(lvl[i])
        );
    end

    assign {clr_lvl, paint, up, down, left, right} = lvl;
    assign dir_rise = |(lvl[3:0] & ~lvl_q[3:0]);
    assign clr_rise = clr_lvl & ~lvl_q[5];

    logic [X_W-1:0]   x, x_n;
    logic [Y_W-1:0]   y, y_n;
    logic [RPT_W-1:0] rpt, rpt_n;
    logic             step;

    // A fresh press steps at once; holding steps every MOVE_CYC cycles.
    always_comb begin
        step  = 1'b0;
        rpt_n = '0;
        if (dir_rise) begin
            step = 1'b1;
        end else if (|lvl[3:0]) begin
            if (rpt == RPT_W'(MOVE_CYC - 1)) begin
                step = 1'b1;
            end else begin
                rpt_n = rpt + RPT_W'(1);
            end
        end
    end

    always_comb begin
        x_n = x;
        y_n = y;
        if (step) begin
            unique case (1'b1)
                right && !left && x != X_MAX: x_n = x + 1'b1;
                left && !right && x != '0:    x_n = x - 1'b1;
                default: ;
            endcase
            unique case (1'b1)
                down && !up && y != Y_MAX: y_n = y + 1'b1;
                up && !down && y != '0:    y_n = y - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            rpt        <= '0;
            lvl_q      <= '0;
            cursor_pos <= '0;
        end else begin
            x          <= x_n;
            y          <= y_n;
            rpt        <= rpt_n;
            lvl_q      <= lvl;
            cursor_pos <= cell_index(x, y);
        end
    end

    ctrl_state_t         state, state_n;
    logic                wr_en_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [COLOUR_W-1:0] wr_data_n;

    // wr_addr doubles as the sweep address counter while clearing.
    always_comb begin
        state_n   = state;
        wr_en_n   = paint;
        wr_addr_n = cursor_pos;
        wr_data_n = sw_colour;
        unique case (state)
            IDLE: begin
                if (clr_rise) begin
                    state_n   = CLEAR;
                    wr_en_n   = 1'b1;
                    wr_addr_n = '0;
                    wr_data_n = CLEAR_COLOUR;
                end
            end
            CLEAR: begin
                if (wr_addr != LAST_ADDR) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_addr + 1'b1;
                    wr_data_n = CLEAR_COLOUR;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

    assign clearing = (state == CLEAR);

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Randomised bench for paint_cursor_ctrl with a behavioural model
// feeding a write scoreboard and per-cycle cursor/clearing checks.
module tb_paint_cursor_ctrl;

    localparam int DEB  = 4;
    localparam int MOVE = 8;
    localparam int FB   = 19200;

    localparam logic [5:0] R = 6'b000001;
    localparam logic [5:0] L = 6'b000010;
    localparam logic [5:0] D = 6'b000100;
    localparam logic [5:0] U = 6'b001000;
    localparam logic [5:0] P = 6'b010000;
    localparam logic [5:0] C = 6'b100000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  btn = '0;
    logic [11:0] sw_colour = '0;
    logic [14:0] cursor_pos;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        clearing;

    always #5 clk = ~clk;

    paint_cursor_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .MOVE_CYC    (MOVE),
        .CLEAR_COLOUR(12'hFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn[3]),
        .btn_down  (btn[2]),
        .btn_left  (btn[1]),
        .btn_right (btn[0]),
        .btn_paint (btn[4]),
        .btn_clear (btn[5]),
        .sw_colour (sw_colour),
        .cursor_pos(cursor_pos),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clearing  (clearing)
    );

    int n_total = 0;
    int n_pass  = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t",
                      name, act, exp, $time);
    endfunction

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        expq[$];
    logic [5:0] hist[$];
    logic [5:0] m_lvl = '0;
    logic [5:0] m_prev = '0;
    int         mx = 0, my = 0, m_cpos = 0;
    int         sweep_start = 0, last_step = 0, k = 0;
    bit         m_clr = 1'b0;

    // Behavioural model, evaluated once per rising clock edge.
    task automatic model_edge();
        logic [5:0] rise;
        logic [5:0] h;
        bit         held, step, nclr, flip;
        k++;
        if (reset) begin
            m_lvl  = '0;
            m_prev = '0;
            mx     = 0;
            my     = 0;
            m_cpos = 0;
            m_clr  = 1'b0;
            hist.delete();
            repeat (DEB + 2) hist.push_back('0);
            return;
        end
        hist.push_back(btn);
        if (hist.size() > 64) void'(hist.pop_front());
        rise = m_lvl & ~m_prev;
        nclr = 1'b0;
        if (m_clr && (k - sweep_start) < FB) begin
            nclr = 1'b1;
            expq.push_back(wr_t'{k - sweep_start, 'hFFF});
        end else if (!m_clr && rise[5]) begin
            sweep_start = k;
            nclr = 1'b1;
            expq.push_back(wr_t'{0, 'hFFF});
        end else if (m_lvl[4]) begin
            expq.push_back(wr_t'{m_cpos, int'(sw_colour)});
        end
        m_clr  = nclr;
        m_cpos = my * 160 + mx;
        held = |m_lvl[3:0];
        step = (rise[3:0] != 0) || (held && (k - last_step) == MOVE);
        if (step) begin
            last_step = k;
            if (m_lvl[0] && !m_lvl[1] && mx < 159) mx++;
            if (m_lvl[1] && !m_lvl[0] && mx > 0)   mx--;
            if (m_lvl[2] && !m_lvl[3] && my < 119) my++;
            if (m_lvl[3] && !m_lvl[2] && my > 0)   my--;
        end
        m_prev = m_lvl;
        // Level flips once DEB consecutive synchronised samples disagree.
        for (int b = 0; b < 6; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                h = hist[hist.size() - 3 - j];
                if (h[b] == m_lvl[b]) flip = 1'b0;
            end
            if (flip) m_lvl[b] = ~m_lvl[b];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    bit mon_on = 1'b0;
    int clr_run = 0;
    int last_run = 0;

    initial forever begin : monitor
        wr_t e;
        bit  exp_wr;
        @(negedge clk);
        if (mon_on) begin
            check("cursor_pos", cursor_pos, m_cpos);
            check("clearing", clearing, m_clr);
            exp_wr = (expq.size() != 0);
            check("wr_en", wr_en, exp_wr);
            if (exp_wr) begin
                e = expq.pop_front();
                if (wr_en) begin
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end
            end
            if (clearing) clr_run++;
            else begin
                if (clr_run != 0) last_run = clr_run;
                clr_run = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [5:0] m, input int n);
        btn = m;
        cyc(n);
    endtask

    task automatic wait_clr(input logic lvl, input int bound,
                            input string name);
        int i = 0;
        while (clearing !== lvl && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (clearing !== lvl) check(name, clearing, lvl);
    endtask

    initial begin
        int i;
        reset = 1'b1;
        cyc(1);
        mon_on = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check("reset cursor_pos", cursor_pos, 0);
        check("reset wr_en", wr_en, 0);
        check("reset clearing", clearing, 0);

        hold(R, 3);
        hold('0, 12);
        check("glitch no move", cursor_pos, 0);

        hold(R, 30);
        hold('0, 12);
        check("hold right 30", cursor_pos, 4);

        hold(R, 8);
        hold('0, 12);
        hold(D, 8);
        hold('0, 12);
        hold(D, 8);
        hold('0, 12);
        check("pos x5 y2", cursor_pos, 325);

        sw_colour = 12'h0F0;
        hold(P, 20);
        check("paint wr_en", wr_en, 1);
        check("paint wr_addr", wr_addr, 325);
        check("paint wr_data", wr_data, 12'h0F0);

        btn = P | C;
        wait_clr(1'b1, 40, "sweep start timeout");
        check("sweep first addr", wr_addr, 0);
        btn = P;
        wait_clr(1'b0, FB + 10, "sweep end timeout");
        cyc(1);
        check("sweep length", last_run, FB);
        check("resume wr_en", wr_en, 1);
        check("resume wr_addr", wr_addr, 325);
        check("resume wr_data", wr_data, 12'h0F0);
        hold('0, 12);

        hold(R, 1400);
        hold('0, 12);
        check("right saturate", cursor_pos, 2 * 160 + 159);
        hold(U, 40);
        hold('0, 12);
        check("up saturate", cursor_pos, 159);
        hold(L | R, 30);
        hold('0, 12);
        check("left+right cancel", cursor_pos, 159);

        repeat (150) begin
            sw_colour = 12'($urandom);
            hold(6'($urandom) & 6'h1F, $urandom_range(1, 24));
        end
        hold('0, 12);

        btn = C;
        wait_clr(1'b1, 40, "abort sweep start timeout");
        btn = '0;
        i = 0;
        while (!(clearing && wr_addr == 15'd1000) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("reached addr 1000", wr_addr, 1000);
        reset = 1'b1;
        cyc(1);
        check("abort wr_en", wr_en, 0);
        check("abort clearing", clearing, 0);
        reset = 1'b0;
        cyc(3);

        btn = C;
        wait_clr(1'b1, 40, "restart sweep timeout");
        check("restart addr", wr_addr, 0);
        hold(C, 5);
        btn = '0;
        wait_clr(1'b0, FB + 10, "restart sweep end timeout");
        cyc(1);
        check("restart sweep length", last_run, FB);
        hold('0, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
